operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Decode-side stage directly upstream of the 32x32 register file.
- Drives the file's two read addresses and captures ReadData1/ReadData2 into a 1-deep output register.
- Bypasses same-cycle writeback data and tracks in-flight destination registers in a scoreboard, stalling on RAW/WAW hazards.
- Uses a valid/ready handshake on both sides.

Parameters:
- WORD_LENGTH, 32, data width; must match the register file.
- N, 32, number of architectural registers.
- ADDR_W, 5, register index width; must satisfy 2**ADDR_W == N.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream instruction fields valid.
- in_ready  out  1  stage accepts in this cycle.
- in_rs  in  ADDR_W  source register A.
- in_rt  in  ADDR_W  source register B.
- in_rd  in  ADDR_W  destination register.
- in_we  in  1  instruction writes in_rd.
- rf_read_reg1  out  ADDR_W  to register file ReadRegister1.
- rf_read_reg2  out  ADDR_W  to register file ReadRegister2.
- rf_read_data1  in  WORD_LENGTH  from register file ReadData1 (combinational read).
- rf_read_data2  in  WORD_LENGTH  from register file ReadData2.
- wb_valid  in  1  writeback bus valid (same signal as the file's RegWrite).
- wb_reg  in  ADDR_W  writeback index (file WriteRegister).
- wb_data  in  WORD_LENGTH  writeback data (file WriteData).
- out_valid  out  1  operands valid.
- out_ready  in  1  downstream accepts.
- out_op_a  out  WORD_LENGTH  operand A.
- out_op_b  out  WORD_LENGTH  operand B.
- out_rd  out  ADDR_W  destination passed through.
- out_we  out  1  write-enable passed through.

Behaviour:
- Interface fixed: one clock, clk; reset is asynchronous and active-high, reset.
- Reset values: out_valid=0, out_op_a=0, out_op_b=0, out_rd=0, out_we=0, scoreboard all 0. in_ready is combinational and reads 1 after reset when in_valid=0.
- rf_read_reg1=in_rs and rf_read_reg2=in_rt, combinational and unregistered.
- Operand select, per source s in {rs, rt}:
  - s==0 -> 0.
  - else wb_valid && wb_reg==s -> wb_data (the file write lands at the edge, so it is not yet readable).
  - else rf data.
- Hazard, per source: s!=0, pend[s]=1, and not (wb_valid && wb_reg==s). WAW: in_we && in_rd!=0 && pend[in_rd] && !(wb_valid && wb_reg==in_rd).
- in_ready = (!out_valid || out_ready) && !hazard_a && !hazard_b && !waw.
- Accept = in_valid && in_ready. On accept, out_* load the selected operands, in_rd, in_we, and out_valid<=1.
- If out_valid && out_ready && !accept, then out_valid<=0 and the data regs hold.
- Output regs hold stable while out_valid && !out_ready.
- Latency: 1 cycle from accept to out_valid.
- Scoreboard (N bits):
  - Set pend[in_rd] on accept when in_we && in_rd!=0.
  - Clear pend[wb_reg] when wb_valid.
  - Same register set and cleared in the same cycle -> set wins.
  - Writeback to a non-pending register: bypass still applies, no scoreboard change.
  - wb_reg==0 is ignored. pend[0] is never set.
- Reset mid-operation: held output and scoreboard are discarded immediately (async). An instruction accepted in the reset cycle is lost.

Optional Feature:
- Macro: OPFETCH_BYPASS_EN.
- Defined: writeback bypass as above; the hazard clears in the writeback cycle.
- Undefined: no bypass mux. Operands come only from rf data (0 for register 0). A pending source stalls through its writeback cycle, and the issue occurs the next cycle, once the file holds the value. The WAW check likewise ignores same-cycle writeback.

Decomposition:
- Package opfetch_pkg holds:
  - WORD_LENGTH, N, ADDR_W defaults.
  - ZERO_REG constant (0).
  - Packed struct typedef for the operand bundle {op_a, op_b, rd, we}.
- One sub-module: opfetch_scoreboard. It holds the N-bit pend vector with set/clear ports and set-wins priority, and exposes combinational pend lookups for rs, rt, rd.

Test Plan:
- Reset, then the file preloaded with r2=7, r4=20. Issue rs=2, rt=4, we=0 -> next cycle out_valid=1, op_a=7, op_b=20. Reset asserted at any time -> out_valid=0 within the same time step.
- Issue rd=25, we=1, then rs=25, with no writeback -> in_ready=0 and held. wb_valid=1, wb_reg=25, wb_data=6 -> same-cycle accept, op_a=6 (with BYPASS_EN). Without BYPASS_EN, accept is one cycle later and op_a=6 comes from the file.
- rs=0, rt=0 while wb_valid, wb_reg=0, wb_data=78 -> op_a=0, op_b=0, no stall.
- out_ready=0 with out_valid=1 -> in_ready=0, and out_op_a/out_op_b stay stable for 5 cycles. Raise out_ready with in_valid=1 -> back-to-back accept, out_valid stays 1.
- Issue rd=31 twice (WAW) -> second stalls until wb_reg=31. In that cycle, accept plus clear on the same register -> pend[31]=1 afterwards.
- Writeback to a non-pending r2=3 while reading rs=2 -> op_a=3 via bypass, scoreboard unchanged.

Source files
------------

// File: rtl/opfetch_pkg.sv
// ---------------------------------------------------------------------------
// opfetch_pkg
//
// Shared definitions for the operand fetch stage that sits directly upstream
// of the 32x32 register file.
//
// Contents:
//   DEF_WORD_LENGTH / DEF_N / DEF_ADDR_W  default data width, register count
//                                         and register index width
//   ZERO_REG                              hard-wired zero register index
//   operand_bundle_t                      {op_a, op_b, rd, we} output bundle
//   is_zero_reg()                         register-index zero test
// ---------------------------------------------------------------------------
package opfetch_pkg;

  localparam int DEF_WORD_LENGTH = 32;
  localparam int DEF_N           = 32;
  localparam int DEF_ADDR_W      = 5;

  localparam int ZERO_REG = 0;

  // Operand bundle captured by the stage's output register. The widths
  // follow the package defaults; the top checks its parameters against them.
  typedef struct packed {
    logic [DEF_WORD_LENGTH-1:0] op_a;
    logic [DEF_WORD_LENGTH-1:0] op_b;
    logic [DEF_ADDR_W-1:0]      rd;
    logic                       we;
  } operand_bundle_t;

  function automatic logic is_zero_reg(input logic [DEF_ADDR_W-1:0] r);
    return r == DEF_ADDR_W'(ZERO_REG);
  endfunction

endpackage

// File: rtl/opfetch_scoreboard.sv
// ---------------------------------------------------------------------------
// opfetch_scoreboard
//
// Tracks which architectural registers have a write in flight. One bit per
// register. A set and a clear aimed at the same register in the same cycle
// leave the bit set (the newly issued writer is still outstanding). Register
// zero is never marked pending, and clears aimed at it are ignored.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   set_en, set_reg     mark set_reg pending at the next edge
//   clr_en, clr_reg     mark clr_reg no longer pending at the next edge
//   look_rs/rt/rd       register indices to look up
//   pend_rs/rt/rd       combinational pending status of those indices
// ---------------------------------------------------------------------------
module opfetch_scoreboard
  import opfetch_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_reg,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_reg,
  input  logic [ADDR_W-1:0] look_rs,
  input  logic [ADDR_W-1:0] look_rt,
  input  logic [ADDR_W-1:0] look_rd,
  output logic              pend_rs,
  output logic              pend_rt,
  output logic              pend_rd
);

  logic [N-1:0] pend;
  logic [N-1:0] set_mask;
  logic [N-1:0] clr_mask;
  logic [N-1:0] pend_next;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && (set_reg != ADDR_W'(ZERO_REG))) begin
      set_mask[set_reg] = 1'b1;
    end
    if (clr_en && (clr_reg != ADDR_W'(ZERO_REG))) begin
      clr_mask[clr_reg] = 1'b1;
    end
    // Clear first, then OR in the set so a same-register collision stays set.
    pend_next           = (pend & ~clr_mask) | set_mask;
    pend_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
    end else begin
      pend <= pend_next;
    end
  end

  assign pend_rs = pend[look_rs];
  assign pend_rt = pend[look_rt];
  assign pend_rd = pend[look_rd];

endmodule

// File: rtl/operand_fetch_stage.sv
// ---------------------------------------------------------------------------
// operand_fetch_stage
//
// Drives the register file read addresses from the incoming instruction,
// selects the two operands and captures them, together with the destination
// fields, into a 1-deep output register behind a valid/ready handshake.
// In-flight destinations are tracked in a scoreboard; a source or
// destination that is still pending stalls the instruction (RAW / WAW).
//
// Build option:
//   OPFETCH_BYPASS_EN  defined   -> writeback data on the bus is forwarded
//                                   to a matching source in the same cycle,
//                                   and that cycle no longer counts as a
//                                   hazard for the written register.
//                      undefined -> operands come only from the register
//                                   file; a pending register stalls through
//                                   its writeback cycle and issues the cycle
//                                   after, once the file holds the value.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   in_valid/in_ready                upstream handshake
//   in_rs, in_rt, in_rd, in_we       instruction register fields
//   rf_read_reg1/2                   register file read addresses
//   rf_read_data1/2                  register file read data (combinational)
//   wb_valid, wb_reg, wb_data        writeback bus (same as file write port)
//   out_valid/out_ready              downstream handshake
//   out_op_a, out_op_b, out_rd,
//   out_we                           captured operand bundle
// ---------------------------------------------------------------------------
module operand_fetch_stage
  import opfetch_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int N           = DEF_N,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_rs,
  input  logic [ADDR_W-1:0]      in_rt,
  input  logic [ADDR_W-1:0]      in_rd,
  input  logic                   in_we,
  output logic [ADDR_W-1:0]      rf_read_reg1,
  output logic [ADDR_W-1:0]      rf_read_reg2,
  input  logic [WORD_LENGTH-1:0] rf_read_data1,
  input  logic [WORD_LENGTH-1:0] rf_read_data2,
  input  logic                   wb_valid,
  input  logic [ADDR_W-1:0]      wb_reg,
  input  logic [WORD_LENGTH-1:0] wb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_LENGTH-1:0] out_op_a,
  output logic [WORD_LENGTH-1:0] out_op_b,
  output logic [ADDR_W-1:0]      out_rd,
  output logic                   out_we
);

  // The operand bundle type is sized by the package defaults, and the
  // scoreboard indexes N bits with an ADDR_W index, so both must agree.
  if ((WORD_LENGTH != DEF_WORD_LENGTH) || (ADDR_W != DEF_ADDR_W)) begin : g_width_check
    $error("operand_fetch_stage: WORD_LENGTH/ADDR_W must match opfetch_pkg defaults");
  end
  if ((1 << ADDR_W) != N) begin : g_count_check
    $error("operand_fetch_stage: 2**ADDR_W must equal N");
  end

  logic                   rs_live;
  logic                   rt_live;
  logic                   rd_live;
  logic                   wb_hit_rs;
  logic                   wb_hit_rt;
  logic                   wb_hit_rd;
  logic [WORD_LENGTH-1:0] src_a;
  logic [WORD_LENGTH-1:0] src_b;
  logic                   pend_rs;
  logic                   pend_rt;
  logic                   pend_rd;
  logic                   hazard_a;
  logic                   hazard_b;
  logic                   waw;
  logic                   accept;
  logic                   sb_set;
  operand_bundle_t        sel_p0;
  operand_bundle_t        bundle_p1;
  logic                   vld_p1;

  // ---- stage p0: address drive, operand select, hazard detect ----

  assign rf_read_reg1 = in_rs;
  assign rf_read_reg2 = in_rt;

  assign rs_live = !is_zero_reg(in_rs);
  assign rt_live = !is_zero_reg(in_rt);
  assign rd_live = !is_zero_reg(in_rd);

`ifdef OPFETCH_BYPASS_EN
  // The file write lands at the coming edge, so a same-cycle reader must
  // take the value from the writeback bus instead of the file.
  assign wb_hit_rs = wb_valid && (wb_reg == in_rs);
  assign wb_hit_rt = wb_valid && (wb_reg == in_rt);
  assign wb_hit_rd = wb_valid && (wb_reg == in_rd);
  assign src_a     = wb_hit_rs ? wb_data : rf_read_data1;
  assign src_b     = wb_hit_rt ? wb_data : rf_read_data2;
`else
  // Without forwarding the writeback cycle still counts as pending; the
  // data bus is only consumed by the register file itself.
  logic unused_wb_data;
  assign wb_hit_rs      = 1'b0;
  assign wb_hit_rt      = 1'b0;
  assign wb_hit_rd      = 1'b0;
  assign src_a          = rf_read_data1;
  assign src_b          = rf_read_data2;
  assign unused_wb_data = ^wb_data;
`endif

  opfetch_scoreboard #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (sb_set),
    .set_reg (in_rd),
    .clr_en  (wb_valid),
    .clr_reg (wb_reg),
    .look_rs (in_rs),
    .look_rt (in_rt),
    .look_rd (in_rd),
    .pend_rs (pend_rs),
    .pend_rt (pend_rt),
    .pend_rd (pend_rd)
  );

  // Register zero is never pending, so the live checks only keep the
  // intent explicit; a writeback that resolves the register lifts the stall.
  assign hazard_a = rs_live && pend_rs && !wb_hit_rs;
  assign hazard_b = rt_live && pend_rt && !wb_hit_rt;
  assign waw      = in_we && rd_live && pend_rd && !wb_hit_rd;

  assign in_ready = (!vld_p1 || out_ready) && !hazard_a && !hazard_b && !waw;
  assign accept   = in_valid && in_ready;
  assign sb_set   = accept && in_we;

  always_comb begin
    sel_p0      = '0;
    sel_p0.op_a = rs_live ? src_a : '0;
    sel_p0.op_b = rt_live ? src_b : '0;
    sel_p0.rd   = in_rd;
    sel_p0.we   = in_we;
  end

  // ---- stage p1: output register ----

  // Data is cleared on reset as well, so outputs read zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      bundle_p1 <= '0;
    end else if (accept) begin
      vld_p1    <= 1'b1;
      bundle_p1 <= sel_p0;
    end else if (vld_p1 && out_ready) begin
      vld_p1    <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_op_a  = bundle_p1.op_a;
  assign out_op_b  = bundle_p1.op_b;
  assign out_rd    = bundle_p1.rd;
  assign out_we    = bundle_p1.we;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NR = 32;
`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rs;
  logic [AW-1:0] in_rt;
  logic [AW-1:0] in_rd;
  logic          in_we;
  logic [AW-1:0] rf_read_reg1;
  logic [AW-1:0] rf_read_reg2;
  logic [W-1:0]  rf_read_data1;
  logic [W-1:0]  rf_read_data2;
  logic          wb_valid;
  logic [AW-1:0] wb_reg;
  logic [W-1:0]  wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_op_a;
  logic [W-1:0]  out_op_b;
  logic [AW-1:0] out_rd;
  logic          out_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rs         (in_rs),
    .in_rt         (in_rt),
    .in_rd         (in_rd),
    .in_we         (in_we),
    .rf_read_reg1  (rf_read_reg1),
    .rf_read_reg2  (rf_read_reg2),
    .rf_read_data1 (rf_read_data1),
    .rf_read_data2 (rf_read_data2),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_op_a      (out_op_a),
    .out_op_b      (out_op_b),
    .out_rd        (out_rd),
    .out_we        (out_we)
  );

  // Register file environment: combinational read, write at the clock edge.
  logic [W-1:0] rf [NR];
  logic         rf_init = 1'b0;

  assign rf_read_data1 = rf[rf_read_reg1];
  assign rf_read_data2 = rf[rf_read_reg2];

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < NR; i++) rf[i] <= 32'h100 + i;
    end else if (wb_valid && wb_reg != 0) begin
      rf[wb_reg] <= wb_data;
    end
  end

  // Reference model: file contents, pending set and the output holding slot.
  logic [W-1:0]  m_rf [NR];
  bit            m_pend [NR];
  bit            m_vld;
  logic [W-1:0]  m_a;
  logic [W-1:0]  m_b;
  logic [AW-1:0] m_rd;
  logic          m_we;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
    m_vld = 1'b0;
    m_a   = '0;
    m_b   = '0;
    m_rd  = '0;
    m_we  = 1'b0;
  endtask

  function automatic logic [W-1:0] m_val(input logic [AW-1:0] s);
    if (s == 0) return '0;
    if (BYP && wb_valid && wb_reg == s) return wb_data;
    return m_rf[s];
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] s);
    return (s != 0) && m_pend[s] && !(BYP && wb_valid && wb_reg == s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs were set at posedge+1 by the caller.
  task automatic tick();
    logic         rdy;
    logic         acc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    rdy = (!m_vld || out_ready) && !m_busy(in_rs) && !m_busy(in_rt)
          && !(in_we && m_busy(in_rd));
    acc = in_valid && rdy;
    a   = m_val(in_rs);
    b   = m_val(in_rt);
    #1;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("rf_read_reg1", 32'(rf_read_reg1), 32'(in_rs));
    chk("rf_read_reg2", 32'(rf_read_reg2), 32'(in_rt));
    @(posedge clk);
    if (wb_valid && wb_reg != 0) begin
      m_rf[wb_reg]   = wb_data;
      m_pend[wb_reg] = 1'b0;
    end
    if (acc) begin
      m_vld = 1'b1;
      m_a   = a;
      m_b   = b;
      m_rd  = in_rd;
      m_we  = in_we;
      if (in_we && in_rd != 0) m_pend[in_rd] = 1'b1;
    end else if (m_vld && out_ready) begin
      m_vld = 1'b0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    chk("out_op_a", out_op_a, m_a);
    chk("out_op_b", out_op_b, m_b);
    chk("out_rd", 32'(out_rd), 32'(m_rd));
    chk("out_we", 32'(out_we), 32'(m_we));
  endtask

  task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] rd, input logic we);
    in_valid = 1'b1;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_we    = we;
  endtask

  task automatic wb(input logic v, input logic [AW-1:0] r, input logic [W-1:0] d);
    wb_valid = v;
    wb_reg   = r;
    wb_data  = d;
  endtask

  // Writeback while reset is held, used to preload the file.
  task automatic reset_wb(input logic [AW-1:0] r, input logic [W-1:0] d);
    wb(1'b1, r, d);
    @(posedge clk);
    m_rf[r] = d;
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_rs     = '0;
    in_rt     = '0;
    in_rd     = '0;
    in_we     = 1'b0;
    out_ready = 1'b1;
    wb(1'b0, '0, '0);
    model_reset();

    rf_init = 1'b1;
    @(posedge clk);
    #1;
    rf_init = 1'b0;
    for (int i = 0; i < NR; i++) m_rf[i] = 32'h100 + i;
    reset_wb(5'd2, 32'd7);
    reset_wb(5'd4, 32'd20);
    wb(1'b0, '0, '0);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_op_a", out_op_a, 32'd0);
    chk("rst_op_b", out_op_b, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_we", 32'(out_we), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    // Basic read of preloaded registers.
    issue(5'd2, 5'd4, 5'd0, 1'b0);
    tick();
    chk("basic_op_a", out_op_a, 32'd7);
    chk("basic_op_b", out_op_b, 32'd20);
    in_valid = 1'b0;
    tick();

    // RAW on r25 resolved by its writeback.
    issue(5'd0, 5'd0, 5'd25, 1'b1);
    tick();
    issue(5'd25, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    wb(1'b1, 5'd25, 32'd6);
    tick();
    wb(1'b0, '0, '0);
    tick();
    chk("raw_op_a", out_op_a, 32'd6);
    in_valid = 1'b0;
    tick();

    // Register zero reads as zero even with a writeback to it.
    issue(5'd0, 5'd0, 5'd0, 1'b0);
    wb(1'b1, 5'd0, 32'd78);
    tick();
    chk("zero_op_a", out_op_a, 32'd0);
    chk("zero_op_b", out_op_b, 32'd0);
    wb(1'b0, '0, '0);
    in_valid = 1'b0;
    tick();

    // Backpressure: hold for 5 cycles, then back-to-back accept.
    issue(5'd2, 5'd4, 5'd3, 1'b0);
    tick();
    out_ready = 1'b0;
    issue(5'd4, 5'd2, 5'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("hold_op_a", out_op_a, 32'd7);
    chk("hold_op_b", out_op_b, 32'd20);
    out_ready = 1'b1;
    tick();
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_op_a", out_op_a, 32'd20);
    in_valid = 1'b0;
    tick();

    // WAW on r31; accept and clear on the same register leaves it pending.
    issue(5'd0, 5'd0, 5'd31, 1'b1);
    tick();
    tick();
    tick();
    wb(1'b1, 5'd31, 32'd55);
    tick();
    wb(1'b0, '0, '0);
    tick();
    issue(5'd31, 5'd0, 5'd0, 1'b0);
    tick();
    chk("waw_pend31", 32'(in_ready), 32'd0);
    wb(1'b1, 5'd31, 32'd56);
    tick();
    wb(1'b0, '0, '0);
    tick();
    chk("waw_read31", out_op_a, 32'd56);
    in_valid = 1'b0;
    tick();

    // Writeback to a non-pending register while it is read.
    issue(5'd2, 5'd0, 5'd0, 1'b0);
    wb(1'b1, 5'd2, 32'd3);
    tick();
    chk("nonpend_op_a", out_op_a, BYP ? 32'd3 : 32'd7);
    wb(1'b0, '0, '0);
    tick();
    chk("nonpend_after", out_op_a, 32'd3);
    in_valid = 1'b0;
    tick();

    // Asynchronous reset mid-operation drops output and scoreboard.
    issue(5'd2, 5'd0, 5'd9, 1'b1);
    tick();
    issue(5'd9, 5'd0, 5'd0, 1'b0);
    reset = 1'b1;
    #1;
    model_reset();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_op_a", out_op_a, 32'd0);
    chk("midrst_out_we", 32'(out_we), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();

    // Randomized traffic on a small register window to provoke hazards.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_rs     = AW'($urandom_range(0, 7));
      in_rt     = AW'($urandom_range(0, 7));
      in_rd     = AW'($urandom_range(0, 7));
      in_we     = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      wb(($urandom_range(0, 9) < 4), AW'($urandom_range(0, 7)), W'($urandom));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wb(1'b0, '0, '0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
